// File: rtl/float_to_int_converter_pkg.sv
// float_to_int_converter_pkg: shared FP32 field layout, flag indices, rounding modes and the
// unpacked-operand record used by the float-domain units.
package float_to_int_converter_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = 24;
    localparam int BIAS = 127;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;
    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rounding_mode_e;
    typedef struct packed {
        logic sign;
        logic signed [9:0] exp;
        logic [SIG_W-1:0] sig;
        logic is_zero;
        logic is_nan;
        logic is_inf;
    } fp32_class_t;
endpackage

// File: rtl/float_to_int_converter_if.sv
// float_to_int_converter_if: operand and result handshakes of the converter.
interface float_to_int_converter_if;
    logic in_valid;
    logic in_ready;
    logic [31:0] in_a;
    logic in_signed;
    logic [2:0] roundingMode;
    logic out_valid;
    logic out_ready;
    logic [31:0] out_bits;
    logic [4:0] exceptionFlags;
    modport master (
        output in_valid, in_a, in_signed, roundingMode, out_ready,
        input in_ready, out_valid, out_bits, exceptionFlags
    );
    modport slave (
        input in_valid, in_a, in_signed, roundingMode, out_ready,
        output in_ready, out_valid, out_bits, exceptionFlags
    );
endinterface

// File: rtl/float_to_int_converter_unpack.sv
// fp32_unpack: splits a binary32 word into sign, unbiased exponent, significand and class.
module fp32_unpack
    import float_to_int_converter_pkg::*;
(
    input logic [31:0] a_i,
    output fp32_class_t cls_o
);
    logic [EXP_W-1:0] ef;
    logic [MAN_W-1:0] mf;
    assign ef = a_i[30:23];
    assign mf = a_i[22:0];
    always_comb begin
        cls_o.sign = a_i[31];
        cls_o.exp = ef == '0 ? -10'sd126 : $signed({2'b0, ef}) - 10'(BIAS);
        cls_o.sig = {ef != '0, mf};
        cls_o.is_zero = ef == '0 && mf == '0;
        cls_o.is_nan = &ef && |mf;
        cls_o.is_inf = &ef && !(|mf);
    end
endmodule

// File: rtl/float_to_int_converter.sv
// float_to_int_converter: two-stage binary32 -> int32/uint32 conversion with RISC-V
// saturation; S1 unpacks, S2 shifts, rounds and saturates into the output register.
module float_to_int_converter
    import float_to_int_converter_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int INT_WIDTH = 32
) (
    input logic clock,
    input logic reset,
    float_to_int_converter_if.slave io
);
    if (EXP_WIDTH != 8 || SIG_WIDTH != 24 || INT_WIDTH != 32) begin : g_bad_cfg
        $error("float_to_int_converter supports only binary32 to 32-bit integers");
    end
    fp32_class_t op_d, op_q;
    rounding_mode_e rm_d, rm_q;
    logic s1_valid_q, signed_q, out_valid_q, s2_free;
    logic [31:0] res_d, out_bits_q;
    logic [4:0] flags_d, flags_q;
    logic signed [9:0] e;
    logic [4:0] rsh;
    logic [3:0] lsh;
    logic [47:0] t;
    logic [32:0] int_part, mag;
    logic g, s, inc, huge, range_nv, nv;
    fp32_unpack u_unpack (.a_i(io.in_a), .cls_o(op_d));
    assign rm_d = io.roundingMode > 3'd4 ? RNE : rounding_mode_e'(io.roundingMode);
    assign s2_free = !out_valid_q || io.out_ready;
    assign io.in_ready = !s1_valid_q || s2_free;
    assign io.out_valid = out_valid_q;
    assign io.out_bits = out_bits_q;
    assign io.exceptionFlags = flags_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            op_q <= '0;
            signed_q <= 1'b0;
            rm_q <= RNE;
        end else if (io.in_ready) begin
            s1_valid_q <= io.in_valid;
            op_q <= op_d;
            signed_q <= io.in_signed;
            rm_q <= rm_d;
        end
    end
    // Right shift keeps 24 bits below the binary point: t[23] is guard, t[22:0] feed sticky.
    always_comb begin
        e = op_q.exp;
        rsh = 5'(10'sd23 - e);
        lsh = 4'(e - 10'sd23);
        t = {op_q.sig, 24'b0} >> rsh;
        huge = e >= 10'sd32;
        int_part = e >= 10'sd23 ? 33'(op_q.sig) << lsh : e >= -10'sd1 ? 33'(t[47:24]) : 33'b0;
        g = e < 10'sd23 && e >= -10'sd1 && t[23];
        s = e < 10'sd23 && (e >= -10'sd1 ? |t[22:0] : |op_q.sig);
        inc = rm_q == RTZ ? 1'b0 :
              rm_q == RDN ? op_q.sign && (g || s) :
              rm_q == RUP ? !op_q.sign && (g || s) :
              rm_q == RMM ? g : g && (s || int_part[0]);
        mag = int_part + 33'(inc);
        range_nv = signed_q ? (op_q.sign ? mag > 33'h080000000 : mag > 33'h07fffffff)
                            : (op_q.sign ? mag != 33'b0 : mag[32]);
        nv = !op_q.is_zero && (op_q.is_nan || op_q.is_inf || huge || range_nv);
        res_d = nv ? ((op_q.is_nan || !op_q.sign) ? {!signed_q, {31{1'b1}}} : {signed_q, 31'b0})
                   : (op_q.sign ? 32'(-mag) : mag[31:0]);
        flags_d = '0;
        flags_d[FLAG_NV] = nv;
        flags_d[FLAG_NX] = !nv && (g || s);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_bits_q <= '0;
            flags_q <= '0;
        end else if (s2_free) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_bits_q <= res_d;
                flags_q <= flags_d;
            end
        end
    end
endmodule

// File: tb/tb_float_to_int_converter.sv
// tb_float_to_int_converter: directed vectors with hand-computed results, streaming under
// random backpressure, and reset with a full pipeline.
module tb_float_to_int_converter;
    typedef struct packed {
        logic [31:0] a;
        logic sgn;
        logic [2:0] rm;
        logic [31:0] bits;
        logic [4:0] fl;
    } vec_t;
    localparam int NV = 26;
    vec_t vecs [NV] = '{
        '{32'h40200000, 1'b1, 3'd0, 32'h00000002, 5'h01},
        '{32'h40200000, 1'b1, 3'd4, 32'h00000003, 5'h01},
        '{32'h40200000, 1'b1, 3'd3, 32'h00000003, 5'h01},
        '{32'h40200000, 1'b1, 3'd2, 32'h00000002, 5'h01},
        '{32'h40200000, 1'b1, 3'd1, 32'h00000002, 5'h01},
        '{32'hC0200000, 1'b1, 3'd0, 32'hFFFFFFFE, 5'h01},
        '{32'hC0200000, 1'b1, 3'd2, 32'hFFFFFFFD, 5'h01},
        '{32'h40200000, 1'b1, 3'd7, 32'h00000002, 5'h01},
        '{32'h3F400000, 1'b1, 3'd0, 32'h00000001, 5'h01},
        '{32'h3F000000, 1'b1, 3'd0, 32'h00000000, 5'h01},
        '{32'h3F000000, 1'b1, 3'd4, 32'h00000001, 5'h01},
        '{32'hC0200000, 1'b0, 3'd1, 32'h00000000, 5'h10},
        '{32'hBE99999A, 1'b0, 3'd1, 32'h00000000, 5'h01},
        '{32'hBE99999A, 1'b0, 3'd2, 32'h00000000, 5'h10},
        '{32'h4F000000, 1'b0, 3'd0, 32'h80000000, 5'h00},
        '{32'hFF800000, 1'b0, 3'd0, 32'h00000000, 5'h10},
        '{32'h4F800000, 1'b0, 3'd1, 32'hFFFFFFFF, 5'h10},
        '{32'h4F7FFFFF, 1'b0, 3'd1, 32'hFFFFFF00, 5'h00},
        '{32'h7FC00000, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10},
        '{32'h4F000000, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10},
        '{32'hCF000000, 1'b1, 3'd0, 32'h80000000, 5'h00},
        '{32'h00000001, 1'b1, 3'd3, 32'h00000001, 5'h01},
        '{32'h80000000, 1'b1, 3'd2, 32'h00000000, 5'h00},
        '{32'hCF000001, 1'b1, 3'd1, 32'h80000000, 5'h10},
        '{32'h4EFFFFFF, 1'b1, 3'd0, 32'h7FFFFF80, 5'h00},
        '{32'h7FC00000, 1'b0, 3'd0, 32'hFFFFFFFF, 5'h10}
    };
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    float_to_int_converter_if bus ();
    float_to_int_converter dut (.clock(clk), .reset(rst), .io(bus));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    task automatic drive(input int i);
        bus.in_a = vecs[i].a;
        bus.in_signed = vecs[i].sgn;
        bus.roundingMode = vecs[i].rm;
    endtask
    // Issues one operand on an idle pipeline and returns the result with its latency.
    task automatic run_op(input int i, output logic [31:0] bits, output logic [4:0] fl, output int lat);
        drive(i);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        bits = bus.out_bits;
        fl = bus.exceptionFlags;
    endtask
    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a = '0;
        bus.in_signed = 1'b0;
        bus.roundingMode = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared += 4;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_bits !== 32'h0) begin mismatched++; $display("FAIL reset out_bits: got %h want 0", bus.out_bits); end
        if (bus.exceptionFlags !== 5'h0) begin mismatched++; $display("FAIL reset flags: got %h want 0", bus.exceptionFlags); end
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    endtask
    task automatic test_directed(input string name, input int lo, input int hi);
        logic [31:0] bits;
        logic [4:0] fl;
        int lat;
        for (int i = lo; i <= hi; i++) begin
            run_op(i, bits, fl, lat);
            compared += 3;
            if (lat !== 2) begin mismatched++; $display("FAIL %s[%0d] latency: got %0d want 2", name, i, lat); end
            if (bits !== vecs[i].bits) begin mismatched++; $display("FAIL %s[%0d] bits a=%h: got %h want %h", name, i, vecs[i].a, bits, vecs[i].bits); end
            if (fl !== vecs[i].fl) begin mismatched++; $display("FAIL %s[%0d] flags a=%h: got %h want %h", name, i, vecs[i].a, fl, vecs[i].fl); end
        end
    endtask
    task automatic test_stream();
        int tx = 0;
        int rx = 0;
        int cyc = 0;
        int extra = 0;
        logic stall = 1'b0;
        logic [31:0] held_bits = '0;
        logic [4:0] held_fl = '0;
        while (rx < 16 && cyc < 400) begin
            @(negedge clk);
            if (stall) begin
                compared++;
                if (!bus.out_valid || bus.out_bits !== held_bits || bus.exceptionFlags !== held_fl) begin
                    mismatched++;
                    $display("FAIL stream hold: got v=%b %h/%h want v=1 %h/%h", bus.out_valid, bus.out_bits, bus.exceptionFlags, held_bits, held_fl);
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid = tx < 16;
            if (tx < 16) drive(tx);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                compared += 2;
                if (bus.out_bits !== vecs[rx].bits) begin mismatched++; $display("FAIL stream[%0d] bits: got %h want %h", rx, bus.out_bits, vecs[rx].bits); end
                if (bus.exceptionFlags !== vecs[rx].fl) begin mismatched++; $display("FAIL stream[%0d] flags: got %h want %h", rx, bus.exceptionFlags, vecs[rx].fl); end
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            stall = bus.out_valid && !bus.out_ready;
            held_bits = bus.out_bits;
            held_fl = bus.exceptionFlags;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        compared += 2;
        if (rx !== 16) begin mismatched++; $display("FAIL stream count: got %0d results want 16", rx); end
        if (extra !== 0) begin mismatched++; $display("FAIL stream duplicates: got %0d extra results want 0", extra); end
    endtask
    task automatic test_reset_mid();
        int stale = 0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        drive(0);
        @(negedge clk);
        drive(1);
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL full in_ready: got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        compared += 4;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL midreset out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_bits !== 32'h0) begin mismatched++; $display("FAIL midreset out_bits: got %h want 0", bus.out_bits); end
        if (bus.exceptionFlags !== 5'h0) begin mismatched++; $display("FAIL midreset flags: got %h want 0", bus.exceptionFlags); end
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL midreset in_ready: got %b want 1", bus.in_ready); end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        compared++;
        if (stale !== 0) begin mismatched++; $display("FAIL midreset stale: got %0d outputs want 0", stale); end
    endtask
    initial begin
        test_reset();
        test_directed("round", 0, 10);
        test_directed("unsigned", 11, 17);
        test_directed("special", 18, NV - 1);
        test_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
